sipo_load_gen: RTL and testbench
================================

Name: sipo_load_gen

Overview:
- Serial-to-parallel loader that sits directly upstream of an enable-gated data register.
- Shifts a serial frame of WIDTH bits into an internal register.
- Presents the assembled word on D and pulses EN for exactly one cycle, so the downstream register captures each complete word once.
- Partial frames never reach D.

Parameters:
- WIDTH, 2, data word width; legal range 1..32.
- EN_POLARITY, 1'b1, active level driven on EN; the inactive level is ~EN_POLARITY.
- MSB_FIRST, 1'b1, 1: first serial bit lands in D[WIDTH-1]; 0: first serial bit lands in D[0].

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- SRST  input  1  synchronous active-low reset, sampled on the CLK rising edge.
- SIN  input  1  serial data bit.
- SVALID  input  1  SIN is valid this cycle.
- START  input  1  marks the current SIN as the first bit of a frame; only meaningful together with SVALID=1.
- D  output  WIDTH  assembled word (registered).
- EN  output  1  one-cycle load strobe for D (registered).
- BUSY  output  1  high while a frame is partially received.
- ERR  output  1  one-cycle parity-error strobe; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset (SRST=0 at a CLK edge):
  - Outputs: D=0, EN=~EN_POLARITY, BUSY=0, ERR=0.
  - Internal state: state=IDLE, bit counter=0, shift register=0.
  - Applies in any state; a reset mid-frame discards the partial frame with no EN.
- States:
  - IDLE: SVALID&START captures bit 0, cnt=1, go to SHIFT. For WIDTH=1, go straight to COMMIT (or PAR when the feature is enabled). SVALID without START is ignored.
  - SHIFT: each SVALID cycle shifts in SIN and increments cnt. Cycles with SVALID=0 hold all state; there is no timeout. When the bit that makes cnt==WIDTH is captured, go to COMMIT (or PAR).
  - COMMIT: one cycle only.
- Restart: SVALID&START while in SHIFT aborts the partial frame. That bit becomes bit 0 and cnt=1. There is no EN and no ERR for the aborted frame.
- Bit order:
  - MSB_FIRST=1: shift left and insert at the LSB; after WIDTH bits, the first bit sits at bit WIDTH-1.
  - MSB_FIRST=0: shift right and insert at the MSB; after WIDTH bits, the first bit sits at bit 0.
- Commit:
  - The last data bit is accepted at edge t. At edge t+1, D is loaded with the completed word.
  - EN=EN_POLARITY during the cycle after edge t+1, exactly one cycle wide.
  - D holds its value until the next commit or reset; D never shows partial data.
- COMMIT accepts SVALID&START as the first bit of the next frame (go to SHIFT). Back-to-back frames therefore need no idle gap. SVALID without START in COMMIT is ignored.
- BUSY=1 exactly when state is SHIFT or PAR. It is registered and mirrors the state.
- Simultaneous reset and START: reset wins.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- When defined:
  - After WIDTH data bits, the FSM enters PAR and waits for one more SVALID bit, the even-parity bit: the XOR of the data bits and the parity bit must be 0.
  - On a match, go to COMMIT as normal; the commit cycle moves one cycle later than the parity-bit edge.
  - On a mismatch, ERR=1 for one cycle, D is unchanged, there is no EN, and the FSM returns to IDLE.
  - START with SVALID while in PAR restarts the frame without ERR.
- When undefined: no PAR state, ERR is constant 0, and commit timing is as stated above.

Test Plan:
- Reset mid-frame (WIDTH=4): START+bits 1,0,1, then SRST=0 for one cycle. Required: D=0, EN inactive, BUSY=0, and no EN ever appears for that frame.
- WIDTH=4, MSB_FIRST=1: START+SIN sequence 1,0,1,1 on consecutive SVALID cycles. Required: one cycle after the 4th bit, D=4'b1011 and EN=1 for exactly 1 cycle; BUSY high only during cycles 1-3.
- MSB_FIRST=0, same stimulus. Required: D=4'b1101 with a single EN pulse.
- SVALID gaps: bits 1,1,0,0 with 2 idle cycles between each. Required: D=4'b1100; EN only after the 4th bit; D unchanged until then.
- Restart plus back-to-back (WIDTH=4): START+1,1, then START+0,0,0,1, then START asserted on the COMMIT cycle followed by 1,1,1 (frame 1,1,1,1). Required: first EN with D=4'b0001, second EN with D=4'b1111; no EN for the aborted frame.
- SIPO_PARITY_CHECK_EN, WIDTH=2, EN_POLARITY=0:
  - Frame 1,0 with parity 1: EN=0 for one cycle and D=2'b10.
  - Frame 1,1 with parity 1: ERR=1 for one cycle, EN stays 1, D stays 2'b10.

Source files
------------

// File: rtl/sipo_load_gen.sv
// sipo_load_gen: serial-to-parallel loader feeding an enable-gated register.
// Shifts a WIDTH-bit serial frame into a private shift register and, once the
// frame is complete, loads it onto D and pulses EN for exactly one cycle.
// Partial frames never reach D.
//
// Parameters:
//   WIDTH       data word width (1..32)
//   EN_POLARITY active level of EN
//   MSB_FIRST   1: first serial bit ends in D[WIDTH-1]; 0: first bit ends in D[0]
//
// Ports:
//   CLK    clock, rising edge
//   SRST   synchronous active-low reset
//   SIN    serial data bit
//   SVALID SIN valid this cycle
//   START  current SIN is bit 0 of a frame (qualified by SVALID)
//   D      assembled word (registered)
//   EN     one-cycle load strobe for D (registered)
//   BUSY   frame partially received (registered)
//   ERR    one-cycle parity-error strobe (registered)
//
// Optional feature macro: SIPO_PARITY_CHECK_EN
//   When defined, each frame carries a trailing even-parity bit; a mismatch
//   pulses ERR and drops the frame. When undefined ERR is constant 0.

module sipo_load_gen #(
   parameter int unsigned WIDTH       = 2,
   parameter logic        EN_POLARITY = 1'b1,
   parameter logic        MSB_FIRST   = 1'b1
) (
   input  logic             CLK,
   input  logic             SRST,
   input  logic             SIN,
   input  logic             SVALID,
   input  logic             START,
   output logic [WIDTH-1:0] D,
   output logic             EN,
   output logic             BUSY,
   output logic             ERR
);

   localparam int unsigned    CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
`ifdef SIPO_PARITY_CHECK_EN
      ,S_PAR   = 2'd3
`endif
   } state_e;

   // State entered once the last data bit has been captured.
`ifdef SIPO_PARITY_CHECK_EN
   localparam state_e S_FULL = S_PAR;
`else
   localparam state_e S_FULL = S_COMMIT;
`endif

   // State entered after capturing bit 0 (a 1-bit frame is already full).
   localparam state_e S_FIRST = (WIDTH == 1) ? S_FULL : S_SHIFT;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic               start_c;

   assign start_c = SVALID & START;

   // Bit 0 of a frame lands at the end the shift moves away from.
   function automatic logic [WIDTH-1:0] first_bit(input logic b);
      if (MSB_FIRST) first_bit = WIDTH'(b);
      else           first_bit = WIDTH'(b) << (WIDTH - 1);
   endfunction

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             b);
      if (MSB_FIRST) shift_in = (cur << 1) | WIDTH'(b);
      else           shift_in = (cur >> 1) | (WIDTH'(b) << (WIDTH - 1));
   endfunction

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (!SRST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         d_q     <= '0;
         en_q    <= ~EN_POLARITY;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         d_q     <= d_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // Next-state and shift datapath.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               shreg_d = first_bit(SIN);
               cnt_d   = CNT_W'(1);
               state_d = S_FIRST;
            end
         end
         S_SHIFT: begin
            if (start_c) begin
               // Restart: the partial frame is silently dropped.
               shreg_d = first_bit(SIN);
               cnt_d   = CNT_W'(1);
               state_d = S_FIRST;
            end else if (SVALID) begin
               shreg_d = shift_in(shreg_q, SIN);
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) state_d = S_FULL;
            end
         end
         S_COMMIT: begin
            // Back-to-back frames may start on the commit cycle.
            if (start_c) begin
               shreg_d = first_bit(SIN);
               cnt_d   = CNT_W'(1);
               state_d = S_FIRST;
            end else begin
               state_d = S_IDLE;
            end
         end
`ifdef SIPO_PARITY_CHECK_EN
         S_PAR: begin
            if (start_c) begin
               shreg_d = first_bit(SIN);
               cnt_d   = CNT_W'(1);
               state_d = S_FIRST;
            end else if (SVALID) begin
               state_d = ((^shreg_q) ^ SIN) ? S_IDLE : S_COMMIT;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered outputs: D/EN load in COMMIT, BUSY follows the next state.
   always_comb begin
      d_d    = d_q;
      en_d   = ~EN_POLARITY;
      busy_d = (state_d == S_SHIFT);
      err_d  = 1'b0;
      if (state_q == S_COMMIT) begin
         d_d  = shreg_q;
         en_d = EN_POLARITY;
      end
`ifdef SIPO_PARITY_CHECK_EN
      if (state_d == S_PAR) busy_d = 1'b1;
      if ((state_q == S_PAR) && SVALID && !START && ((^shreg_q) ^ SIN))
         err_d = 1'b1;
`endif
   end

   assign D    = d_q;
   assign EN   = en_q;
   assign BUSY = busy_q;
   assign ERR  = err_q;

endmodule

// File: tb/tb_sipo_load_gen.sv
// Directed bench for sipo_load_gen: two WIDTH=4 instances (MSB- and
// LSB-first) share one stimulus; a WIDTH=2, active-low EN instance has its own.

module tb_sipo_load_gen;

   logic       clk = 1'b0;
   logic       srst;
   logic       sin, sv, st;
   logic       sin2, sv2, st2;

   logic [3:0] d_m, d_l;
   logic       en_m, busy_m, err_m;
   logic       en_l, busy_l, err_l;
   logic [1:0] d_w;
   logic       en_w, busy_w, err_w;

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   sipo_load_gen #(.WIDTH(4), .EN_POLARITY(1'b1), .MSB_FIRST(1'b1)) u_msb (
      .CLK(clk), .SRST(srst), .SIN(sin), .SVALID(sv), .START(st),
      .D(d_m), .EN(en_m), .BUSY(busy_m), .ERR(err_m));

   sipo_load_gen #(.WIDTH(4), .EN_POLARITY(1'b1), .MSB_FIRST(1'b0)) u_lsb (
      .CLK(clk), .SRST(srst), .SIN(sin), .SVALID(sv), .START(st),
      .D(d_l), .EN(en_l), .BUSY(busy_l), .ERR(err_l));

   sipo_load_gen #(.WIDTH(2), .EN_POLARITY(1'b0), .MSB_FIRST(1'b1)) u_w2 (
      .CLK(clk), .SRST(srst), .SIN(sin2), .SVALID(sv2), .START(st2),
      .D(d_w), .EN(en_w), .BUSY(busy_w), .ERR(err_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic s, input logic v, input logic b);
      sin = s; sv = v; st = b;
   endtask

   task automatic drv2(input logic s, input logic v, input logic b);
      sin2 = s; sv2 = v; st2 = b;
   endtask

   initial begin
      srst = 1'b0;
      drv(0, 0, 0);
      drv2(0, 0, 0);
      tick(); tick();
      chk("rst_d_m",    32'(d_m),    32'h0);
      chk("rst_en_m",   32'(en_m),   32'h0);
      chk("rst_busy_m", 32'(busy_m), 32'h0);
      chk("rst_err_m",  32'(err_m),  32'h0);
      chk("rst_en_w",   32'(en_w),   32'h1);
      chk("rst_d_w",    32'(d_w),    32'h0);
      srst = 1'b1;

      // Reset mid-frame: START+1,0,1 then reset.
      drv(1, 1, 1); tick();
      chk("mid_busy", 32'(busy_m), 32'h1);
      drv(0, 1, 0); tick();
      drv(1, 1, 0); tick();
      srst = 1'b0; drv(0, 0, 0); tick();
      srst = 1'b1;
      chk("mid_d",    32'(d_m),    32'h0);
      chk("mid_en",   32'(en_m),   32'h0);
      chk("mid_busy0",32'(busy_m), 32'h0);
      drv(1, 1, 0); tick();          // no START: ignored in IDLE
      drv(0, 0, 0); tick();
      chk("mid_noen",  32'(en_m),   32'h0);
      chk("mid_nobsy", 32'(busy_m), 32'h0);
      tick();
      chk("mid_noen2", 32'(en_m),   32'h0);

      // Frame 1,0,1,1 on consecutive cycles.
      drv(1, 1, 1); tick();
      chk("f1_busy1", 32'(busy_m), 32'h1);
      drv(0, 1, 0); tick();
      chk("f1_busy2", 32'(busy_m), 32'h1);
      drv(1, 1, 0); tick();
      chk("f1_busy3", 32'(busy_m), 32'h1);
      drv(1, 1, 0); tick();
      chk("f1_busy4", 32'(busy_m), 32'h0);
      chk("f1_en_pre",32'(en_m),   32'h0);
      chk("f1_d_pre", 32'(d_m),    32'h0);
      drv(0, 0, 0); tick();
      chk("f1_d_m",   32'(d_m),    32'hB);
      chk("f1_en_m",  32'(en_m),   32'h1);
      chk("f1_d_l",   32'(d_l),    32'hD);
      chk("f1_en_l",  32'(en_l),   32'h1);
      tick();
      chk("f1_en_off",32'(en_m),   32'h0);
      chk("f1_en_offl",32'(en_l),  32'h0);
      chk("f1_d_hold",32'(d_m),    32'hB);

      // Frame 1,1,0,0 with two idle cycles between bits.
      drv(1, 1, 1); tick();
      drv(0, 0, 0); tick(); tick();
      chk("gap_en1",  32'(en_m),   32'h0);
      chk("gap_d1",   32'(d_m),    32'hB);
      drv(1, 1, 0); tick();
      drv(0, 0, 0); tick(); tick();
      chk("gap_en2",  32'(en_m),   32'h0);
      drv(0, 1, 0); tick();
      drv(0, 0, 0); tick(); tick();
      chk("gap_busy", 32'(busy_m), 32'h1);
      chk("gap_d3",   32'(d_m),    32'hB);
      drv(0, 1, 0); tick();
      chk("gap_en4",  32'(en_m),   32'h0);
      chk("gap_d4",   32'(d_m),    32'hB);
      drv(0, 0, 0); tick();
      chk("gap_d_m",  32'(d_m),    32'hC);
      chk("gap_en_m", 32'(en_m),   32'h1);
      chk("gap_d_l",  32'(d_l),    32'h3);
      tick();
      chk("gap_en_off",32'(en_m),  32'h0);

      // Restart then back-to-back frames.
      drv(1, 1, 1); tick();
      drv(1, 1, 0); tick();
      drv(0, 1, 1); tick();          // restart
      chk("rs_en",    32'(en_m),   32'h0);
      chk("rs_busy",  32'(busy_m), 32'h1);
      drv(0, 1, 0); tick();
      drv(0, 1, 0); tick();
      chk("rs_en2",   32'(en_m),   32'h0);
      drv(1, 1, 0); tick();
      chk("rs_en3",   32'(en_m),   32'h0);
      chk("rs_d_old", 32'(d_m),    32'hC);
      drv(1, 1, 1); tick();          // START on the commit cycle
      chk("b2b_d1_m", 32'(d_m),    32'h1);
      chk("b2b_d1_l", 32'(d_l),    32'h8);
      chk("b2b_en1",  32'(en_m),   32'h1);
      chk("b2b_busy", 32'(busy_m), 32'h1);
      drv(1, 1, 0); tick();
      chk("b2b_en_off",32'(en_m),  32'h0);
      chk("b2b_hold", 32'(d_m),    32'h1);
      drv(1, 1, 0); tick();
      drv(1, 1, 0); tick();
      chk("b2b_en_pre",32'(en_m),  32'h0);
      drv(0, 0, 0); tick();
      chk("b2b_d2_m", 32'(d_m),    32'hF);
      chk("b2b_d2_l", 32'(d_l),    32'hF);
      chk("b2b_en2",  32'(en_m),   32'h1);
      tick();
      chk("b2b_en2_off",32'(en_m), 32'h0);

      // WIDTH=2, active-low EN.
      drv2(1, 1, 1); tick();
      chk("w2_busy1", 32'(busy_w), 32'h1);
      drv2(0, 1, 0); tick();
`ifdef SIPO_PARITY_CHECK_EN
      chk("w2_busy_par", 32'(busy_w), 32'h1);
      drv2(1, 1, 0); tick();         // parity bit: 1^0^1 = 0
`endif
      chk("w2_busy0", 32'(busy_w), 32'h0);
      chk("w2_en_pre",32'(en_w),   32'h1);
      drv2(0, 0, 0); tick();
      chk("w2_d1",    32'(d_w),    32'h2);
      chk("w2_en1",   32'(en_w),   32'h0);
      tick();
      chk("w2_en_off",32'(en_w),   32'h1);
      drv2(1, 1, 1); tick();
      drv2(1, 1, 0); tick();
`ifdef SIPO_PARITY_CHECK_EN
      drv2(1, 1, 0); tick();         // parity bit: 1^1^1 = 1 -> error
      chk("w2_err",   32'(err_w),  32'h1);
      chk("w2_err_en",32'(en_w),   32'h1);
      chk("w2_err_busy",32'(busy_w),32'h0);
      drv2(0, 0, 0); tick();
      chk("w2_err_off",32'(err_w), 32'h0);
      chk("w2_err_noen",32'(en_w), 32'h1);
      chk("w2_err_d", 32'(d_w),    32'h2);
`else
      drv2(0, 0, 0); tick();
      chk("w2_d2",    32'(d_w),    32'h3);
      chk("w2_en2",   32'(en_w),   32'h0);
      chk("w2_err0",  32'(err_w),  32'h0);
`endif
      tick();
      chk("w2_en_end",32'(en_w),   32'h1);
      chk("err_m_end",32'(err_m),  32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
